// File: rtl/alu_fault_monitor.sv
// rtl/alu_fault_monitor.sv - ALU result monitor with replay-on-error and saturating error counters
// Qualifies checker flags by opcode, requests replays up to MAX_RETRY, then reports a fault.

module alu_fault_monitor #(
  parameter int MAX_RETRY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [31:0] data_result,
  input  logic        adder_has_error,
  input  logic        sra_has_error,
  input  logic        sll_has_error,
  input  logic        clear_counts,
  output logic        in_ready,
  output logic        replay,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic        out_fault,
  output logic [7:0]  adder_err_count,
  output logic [7:0]  shift_err_count
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_CNT = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] retry_cnt;

  logic adder_op;
  logic sll_op;
  logic sra_op;
  logic adder_hit;
  logic shift_hit;
  logic qerr;
  logic accept;
  logic exhausted;

  always_comb begin
    adder_op  = (ctrl_ALUopcode == 5'd0) || (ctrl_ALUopcode == 5'd1);
    sll_op    = (ctrl_ALUopcode == 5'd4);
    sra_op    = (ctrl_ALUopcode == 5'd5);
    accept    = in_valid & in_ready;
    adder_hit = accept & adder_op & adder_has_error;
    shift_hit = accept & ((sll_op & sll_has_error) | (sra_op & sra_has_error));
    qerr      = (adder_op & adder_has_error) | (sll_op & sll_has_error) |
                (sra_op & sra_has_error);
    exhausted = (retry_cnt == MAX_CNT);
  end

  // in_ready is kept registered alongside the state so it is low exactly in REPLAY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      in_ready   <= 1'b1;
      replay     <= 1'b0;
      out_valid  <= 1'b0;
      out_fault  <= 1'b0;
      out_result <= '0;
    end else begin
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      replay    <= 1'b0;
      case (state)
        REPLAY: begin
          state    <= WAIT;
          in_ready <= 1'b1;
        end
        default: begin
          if (accept) begin
            if (!qerr || exhausted) begin
              out_valid  <= 1'b1;
              out_fault  <= qerr;
              out_result <= data_result;
              retry_cnt  <= '0;
              state      <= IDLE;
              in_ready   <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= REPLAY;
              replay    <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Every erroneous attempt counts, replays included; clear wins over an increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      adder_err_count <= '0;
      shift_err_count <= '0;
    end else if (clear_counts) begin
      adder_err_count <= '0;
      shift_err_count <= '0;
    end else begin
      if (adder_hit && adder_err_count != 8'hFF)
        adder_err_count <= adder_err_count + 8'd1;
      if (shift_hit && shift_err_count != 8'hFF)
        shift_err_count <= shift_err_count + 8'd1;
    end
  end

endmodule
